// File: rtl/fix_framer.sv
// FIX message framer: finds "8=" message starts, forwards the body through the
// SOH that precedes the "10=" trailer, strips the trailer tag and hands the
// three checksum digits to the checksum stage on a separate qualifier.
module fix_framer #(
  parameter int unsigned MAX_LEN = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       start_o,
  output logic       end_o,
  output logic [7:0] cks_digit_o,
  output logic       cks_valid_o,
  output logic       msg_done_o,
  output logic       err_o
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 13;
  localparam int unsigned DCNT_W = 2;
  localparam int unsigned HOLD_N = 3;
  localparam int unsigned HCNT_W = 2;

  localparam logic [BYTE_W-1:0] CH_SOH = 8'h01;
  localparam logic [BYTE_W-1:0] CH_0   = 8'h30;
  localparam logic [BYTE_W-1:0] CH_1   = 8'h31;
  localparam logic [BYTE_W-1:0] CH_8   = 8'h38;
  localparam logic [BYTE_W-1:0] CH_9   = 8'h39;
  localparam logic [BYTE_W-1:0] CH_EQ  = 8'h3D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BODY,
    S_TAG1,
    S_TAG2,
    S_TAG3,
    S_DRAIN,
    S_CKS
  } state_e;

  state_e                          state_q, state_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [DCNT_W-1:0]               dcnt_q, dcnt_d;
  logic [HOLD_N-1:0][BYTE_W-1:0]   hold_q, hold_d;
  logic [HCNT_W-1:0]               hcnt_q, hcnt_d;

  logic                            ready_q, ready_d;
  logic [BYTE_W-1:0]               data_q, data_d;
  logic                            dvalid_q, dvalid_d;
  logic                            start_q, start_d;
  logic                            end_q, end_d;
  logic [BYTE_W-1:0]               cks_q, cks_d;
  logic                            cksv_q, cksv_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;

  logic                            accept_c;
  logic                            fwd_c;
  logic [BYTE_W-1:0]               fwd_byte_c;
  logic                            is_digit_c;

  assign accept_c   = byte_valid_i && ready_q;
  assign is_digit_c = (byte_i >= CH_0) && (byte_i <= CH_9);

  // Next-state, counters, hold buffer and registered-output values.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    dcnt_d     = dcnt_q;
    hold_d     = hold_q;
    hcnt_d     = hcnt_q;
    data_d     = data_q;
    cks_d      = cks_q;
    dvalid_d   = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    cksv_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fwd_c      = 1'b0;
    fwd_byte_c = '0;

    case (state_q)
      S_IDLE: begin
        // Hunt for the '8' of "8=" and drop everything else.
        if (accept_c && (byte_i == CH_8)) begin
          data_d   = byte_i;
          dvalid_d = 1'b1;
          start_d  = 1'b1;
          len_d    = LEN_W'(1);
          state_d  = S_BODY;
        end
      end

      S_BODY: begin
        if (accept_c) begin
          fwd_c      = 1'b1;
          fwd_byte_c = byte_i;
          if (byte_i == CH_SOH) begin
            state_d = S_TAG1;
          end
        end
      end

      S_TAG1: begin
        // A '1' right after SOH may open the trailer, so it is held back.
        if (accept_c) begin
          if (byte_i == CH_1) begin
            state_d = S_TAG2;
          end else begin
            fwd_c      = 1'b1;
            fwd_byte_c = byte_i;
            state_d    = (byte_i == CH_SOH) ? S_TAG1 : S_BODY;
          end
        end
      end

      S_TAG2: begin
        if (accept_c) begin
          if (byte_i == CH_0) begin
            state_d = S_TAG3;
          end else begin
            // Not a trailer: release the held '1' now, queue the current byte.
            fwd_c      = 1'b1;
            fwd_byte_c = CH_1;
            hold_d     = '0;
            hold_d[0]  = byte_i;
            hcnt_d     = HCNT_W'(1);
            state_d    = S_DRAIN;
          end
        end
      end

      S_TAG3: begin
        if (accept_c) begin
          if (byte_i == CH_EQ) begin
            end_d   = 1'b1;
            dcnt_d  = '0;
            state_d = S_CKS;
          end else begin
            // Not a trailer: release '1' now, queue '0' and the current byte.
            fwd_c      = 1'b1;
            fwd_byte_c = CH_1;
            hold_d     = '0;
            hold_d[0]  = CH_0;
            hold_d[1]  = byte_i;
            hcnt_d     = HCNT_W'(2);
            state_d    = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Emit one queued byte per cycle; the last one decides where to resume.
        fwd_c      = 1'b1;
        fwd_byte_c = hold_q[0];
        hold_d[0]  = hold_q[1];
        hold_d[1]  = hold_q[2];
        hold_d[2]  = '0;
        hcnt_d     = hcnt_q - HCNT_W'(1);
        if (hcnt_q <= HCNT_W'(1)) begin
          hcnt_d  = '0;
          state_d = (hold_q[0] == CH_SOH) ? S_TAG1 : S_BODY;
        end
      end

      S_CKS: begin
        // Exactly three digits followed by SOH close the message.
        if (accept_c) begin
          if (is_digit_c) begin
            if (dcnt_q == DCNT_W'(3)) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              cks_d  = byte_i;
              cksv_d = 1'b1;
              dcnt_d = dcnt_q + DCNT_W'(1);
            end
          end else if ((byte_i == CH_SOH) && (dcnt_q == DCNT_W'(3))) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Common forwarding path with the message length limit.
    if (fwd_c) begin
      if (len_q == LEN_W'(MAX_LEN)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        hold_d  = '0;
        hcnt_d  = '0;
      end else begin
        data_d   = fwd_byte_c;
        dvalid_d = 1'b1;
        len_d    = len_q + LEN_W'(1);
      end
    end

    ready_d = (state_d != S_DRAIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      dcnt_q   <= '0;
      hold_q   <= '0;
      hcnt_q   <= '0;
      ready_q  <= 1'b1;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      cks_q    <= '0;
      cksv_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      dcnt_q   <= dcnt_d;
      hold_q   <= hold_d;
      hcnt_q   <= hcnt_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      start_q  <= start_d;
      end_q    <= end_d;
      cks_q    <= cks_d;
      cksv_q   <= cksv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ready_o      = ready_q;
  assign data_o       = data_q;
  assign data_valid_o = dvalid_q;
  assign start_o      = start_q;
  assign end_o        = end_q;
  assign cks_digit_o  = cks_q;
  assign cks_valid_o  = cksv_q;
  assign msg_done_o   = done_q;
  assign err_o        = err_q;

endmodule
